// File: rtl/xpb_accumulator_pkg.sv
// Shared constants and state type for the xpb accumulation stage and its ROM bank.
package xpb_accumulator_pkg;

  localparam int XPB_WIDTH  = 1024;
  localparam int DIGIT_BITS = 5;
  localparam int NUM_DIGITS = 16;
  localparam int IDX_BITS   = $clog2(NUM_DIGITS);
  localparam int ACC_WIDTH  = XPB_WIDTH + $clog2(NUM_DIGITS + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } xpb_state_e;

endpackage

// File: rtl/xpb_accumulator.sv
// Walks the upper-word digits one per cycle, summing the ROM residues onto the lower word.
// Result is the unreduced wide sum, held under a valid/ready handshake.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | waiting for start_i; ROM address lines parked at 0
// ST_ACCUM | one digit per cycle: acc += xpb_value_i, cnt advances
// ST_DONE  | valid_o high, result_o stable until ready_i
module xpb_accumulator #(
  parameter int XPB_WIDTH  = xpb_accumulator_pkg::XPB_WIDTH,
  parameter int DIGIT_BITS = xpb_accumulator_pkg::DIGIT_BITS,
  parameter int NUM_DIGITS = xpb_accumulator_pkg::NUM_DIGITS,
  parameter int IDX_BITS   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
  parameter int ACC_WIDTH  = XPB_WIDTH + $clog2(NUM_DIGITS + 1)
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start_i,
  input  logic [XPB_WIDTH-1:0]             low_i,
  input  logic [NUM_DIGITS*DIGIT_BITS-1:0] digits_i,
  output logic [IDX_BITS-1:0]              xpb_sel_o,
  output logic [DIGIT_BITS-1:0]            xpb_digit_o,
  input  logic [XPB_WIDTH-1:0]             xpb_value_i,
  output logic                             busy_o,
  output logic                             valid_o,
  input  logic                             ready_i,
  output logic [ACC_WIDTH-1:0]             result_o
);
  import xpb_accumulator_pkg::*;

  localparam int                  DIG_W    = NUM_DIGITS * DIGIT_BITS;
  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NUM_DIGITS - 1);

  xpb_state_e           r_state;
  logic [ACC_WIDTH-1:0] r_acc;
  logic [DIG_W-1:0]     r_digits;
  logic [IDX_BITS-1:0]  r_cnt;
  logic                 r_busy;
  logic                 r_valid;

  logic                 w_accum;
  logic [ACC_WIDTH-1:0] w_addend;
  logic [ACC_WIDTH-1:0] w_low_ext;

  assign w_accum   = (r_state == ST_ACCUM);
  assign w_addend  = {{(ACC_WIDTH - XPB_WIDTH){1'b0}}, xpb_value_i};
  assign w_low_ext = {{(ACC_WIDTH - XPB_WIDTH){1'b0}}, low_i};

  // The digit register shifts down every ACCUM cycle, so the digit at
  // position cnt is always the low slice and no wide mux is needed.
  assign xpb_sel_o   = w_accum ? r_cnt : '0;
  assign xpb_digit_o = w_accum ? r_digits[DIGIT_BITS-1:0] : '0;

  assign busy_o   = r_busy;
  assign valid_o  = r_valid;
  assign result_o = r_acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_acc    <= '0;
      r_digits <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_valid  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            r_acc    <= w_low_ext;
            r_digits <= digits_i;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          r_acc    <= r_acc + w_addend;
          r_digits <= r_digits >> DIGIT_BITS;
          if (r_cnt == LAST_IDX) begin
            r_valid <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          // start_i in the handshake cycle is dropped; it is taken next IDLE cycle.
          if (ready_i) begin
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_valid <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
